// File: rtl/z80_bus_dma_arbiter.sv
// z80_bus_dma_arbiter: lends the Z80 memory bus to a single DMA requester.
// Define DMA_HOLDOFF_EN to keep the bus with the CPU for HOLDOFF clocks after release.
module z80_bus_dma_arbiter #(
  parameter int MEM_WAIT  = 2,
  parameter int MAX_BURST = 16,
  parameter int HOLDOFF   = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        busrq_n,
  input  logic        busak_n,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic        dma_last,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  output logic        bus_owned,
  output logic [15:0] mem_a,
  output logic [7:0]  mem_dout,
  input  logic [7:0]  mem_din,
  output logic        mem_mreq_n,
  output logic        mem_rd_n,
  output logic        mem_wr_n
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_SETUP, S_ACCESS,
    S_ACK, S_GRANTED, S_RELEASE, S_HOLDOFF
  } state_t;

`ifdef DMA_HOLDOFF_EN
  localparam bit USE_HOLDOFF = 1'b1;
`else
  localparam bit USE_HOLDOFF = 1'b0;
`endif

  state_t     state, state_nx;
  logic [3:0] wait_cnt;
  logic [7:0] burst_cnt;
  logic [7:0] hold_cnt;
  logic       we_q;
  logic       last_q;
  logic [7:0] wdata_q;
  logic       wait_done;
  logic       burst_hit;
  logic       hold_done;

  logic       busrq_d;
  logic       owned_d;
  logic       ack_d;
  logic       mreq_d;
  logic       rd_d;
  logic       wr_d;
  logic [7:0] dout_d;

  assign wait_done = wait_cnt == 4'(MEM_WAIT);
  assign burst_hit = burst_cnt == 8'(MAX_BURST);
  assign hold_done = hold_cnt == 8'(HOLDOFF - 1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      wait_cnt  <= 4'd0;
      burst_cnt <= 8'd0;
      hold_cnt  <= 8'd0;
    end else begin
      state    <= state_nx;
      wait_cnt <= (state == S_ACCESS) ? wait_cnt + 4'd1 : 4'd0;
      hold_cnt <= (state == S_HOLDOFF) ? hold_cnt + 8'd1 : 8'd0;
      if (state_nx == S_RELEASE)
        burst_cnt <= 8'd0;
      else if (state_nx == S_ACK)
        burst_cnt <= burst_cnt + 8'd1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (dma_req) state_nx = S_REQ;
      S_REQ: begin
        if (!busak_n)     state_nx = S_SETUP;
        else if (!dma_req) state_nx = S_RELEASE;
      end
      S_SETUP:   state_nx = S_ACCESS;
      S_ACCESS:  if (wait_done) state_nx = S_ACK;
      S_ACK:     state_nx = (last_q || burst_hit) ? S_RELEASE : S_GRANTED;
      S_GRANTED: if (dma_req) state_nx = S_SETUP;
      S_RELEASE: begin
        if (busak_n)
          state_nx = USE_HOLDOFF ? S_HOLDOFF : S_IDLE;
      end
      S_HOLDOFF: if (hold_done) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Outputs are registered, so decode them from the state being entered.
  always_comb begin
    busrq_d = 1'b1;
    owned_d = 1'b0;
    ack_d   = 1'b0;
    mreq_d  = 1'b1;
    rd_d    = 1'b1;
    wr_d    = 1'b1;
    dout_d  = 8'hFF;
    unique case (state_nx)
      S_REQ: busrq_d = 1'b0;
      S_SETUP, S_GRANTED: begin
        busrq_d = 1'b0;
        owned_d = 1'b1;
      end
      S_ACK: begin
        busrq_d = 1'b0;
        owned_d = 1'b1;
        ack_d   = 1'b1;
      end
      S_ACCESS: begin
        busrq_d = 1'b0;
        owned_d = 1'b1;
        mreq_d  = 1'b0;
        rd_d    = we_q;
        wr_d    = !we_q;
        if (we_q) dout_d = wdata_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busrq_n    <= 1'b1;
      bus_owned  <= 1'b0;
      dma_ack    <= 1'b0;
      dma_rdata  <= 8'h00;
      mem_a      <= 16'h0000;
      mem_dout   <= 8'hFF;
      mem_mreq_n <= 1'b1;
      mem_rd_n   <= 1'b1;
      mem_wr_n   <= 1'b1;
      we_q       <= 1'b0;
      last_q     <= 1'b0;
      wdata_q    <= 8'h00;
    end else begin
      busrq_n    <= busrq_d;
      bus_owned  <= owned_d;
      dma_ack    <= ack_d;
      mem_dout   <= dout_d;
      mem_mreq_n <= mreq_d;
      mem_rd_n   <= rd_d;
      mem_wr_n   <= wr_d;
      if (state_nx == S_SETUP) begin
        mem_a   <= dma_addr;
        we_q    <= dma_we;
        last_q  <= dma_last;
        wdata_q <= dma_wdata;
      end
      if (state == S_ACCESS && wait_done && !we_q)
        dma_rdata <= mem_din;
    end
  end

endmodule

// File: tb/tb_z80_bus_dma_arbiter.sv
// tb_z80_bus_dma_arbiter: directed bench with a CPU responder, memory and a
// transaction-level scoreboard checked every cycle.
module tb_z80_bus_dma_arbiter;

  localparam int MEM_WAIT  = 2;
  localparam int MAX_BURST = 4;
  localparam int HOLDOFF   = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        busrq_n;
  logic        busak_n;
  logic        dma_req;
  logic        dma_we;
  logic        dma_last;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_ack;
  logic [7:0]  dma_rdata;
  logic        bus_owned;
  logic [15:0] mem_a;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        mem_mreq_n;
  logic        mem_rd_n;
  logic        mem_wr_n;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        last;
  } xfer_t;

  logic [7:0] mem [0:65535];
  xfer_t      exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ak_fall_cyc = 0;
  int last_ack_cyc = 0;
  int last_run = 0;
  int acks = 0;
  int grants = 0;
  int releases = 0;
  int rsp_cnt = 0;
  bit no_ack = 1'b0;
  bit start_cmp = 1'b0;

  bit    c_prev_ack = 1'b0;
  bit    c_exp_rel = 1'b0;
  bit    c_prev_owned = 1'b0;
  int    c_run = 0;
  int    c_in_grant = 0;
  xfer_t c_cur;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign mem_din = mem[mem_a];

  z80_bus_dma_arbiter #(
    .MEM_WAIT (MEM_WAIT),
    .MAX_BURST(MAX_BURST),
    .HOLDOFF  (HOLDOFF)
  ) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .busrq_n   (busrq_n),
    .busak_n   (busak_n),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_last  (dma_last),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_ack   (dma_ack),
    .dma_rdata (dma_rdata),
    .bus_owned (bus_owned),
    .mem_a     (mem_a),
    .mem_dout  (mem_dout),
    .mem_din   (mem_din),
    .mem_mreq_n(mem_mreq_n),
    .mem_rd_n  (mem_rd_n),
    .mem_wr_n  (mem_wr_n)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // CPU: grants three clocks after busrq_n falls, drops busak_n on release.
  initial begin
    busak_n = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (busrq_n !== 1'b0) begin
        rsp_cnt = 0;
        busak_n = 1'b1;
      end else if (busak_n && !no_ack) begin
        rsp_cnt++;
        if (rsp_cnt >= 3) begin
          busak_n = 1'b0;
          ak_fall_cyc = cyc;
        end
      end
    end
  end

  // Scoreboard: compares bus activity against queued transfers each cycle.
  initial begin
    wait (start_cmp);
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        exp_q.delete();
        c_run = 0;
        c_in_grant = 0;
        c_prev_ack = 1'b0;
        c_prev_owned = 1'b0;
        continue;
      end
      if (exp_q.size() != 0) c_cur = exp_q[0];
      else c_cur = '0;
      if (!bus_owned)
        check("strobes_released", {mem_mreq_n, mem_rd_n, mem_wr_n}, 3'b111);
      else
        check("busrq_held", busrq_n, 1'b0);
      if (bus_owned && !c_prev_owned) grants++;
      if (!bus_owned && c_prev_owned) releases++;
      if (!bus_owned) c_in_grant = 0;
      if (c_prev_ack) begin
        check("owned_after_ack", bus_owned, !c_exp_rel);
        check("busrq_after_ack", busrq_n, c_exp_rel);
      end
      if (!mem_rd_n || !mem_wr_n) begin
        check("strobe_expected", exp_q.size() != 0, 1'b1);
        check("mreq_with_strobe", mem_mreq_n, 1'b0);
        check("rd_dir", mem_rd_n, c_cur.we);
        check("wr_dir", mem_wr_n, !c_cur.we);
        check("addr", mem_a, c_cur.addr);
        c_run++;
        if (!mem_wr_n && !mem_mreq_n) mem[mem_a] = mem_dout;
      end
      check("dout", mem_dout, mem_wr_n ? 8'hFF : c_cur.data);
      if (dma_ack) begin
        check("ack_pulse", c_prev_ack, 1'b0);
        check("ack_expected", exp_q.size() != 0, 1'b1);
        check("strobe_len", c_run, 1 + MEM_WAIT);
        if (c_cur.we) check("mem_written", mem[c_cur.addr], c_cur.data);
        else check("rdata", dma_rdata, mem[c_cur.addr]);
        last_run = c_run;
        c_run = 0;
        last_ack_cyc = cyc;
        acks++;
        c_in_grant++;
        c_exp_rel = c_cur.last || (c_in_grant == MAX_BURST);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      c_prev_ack = dma_ack;
      c_prev_owned = bus_owned;
    end
  end

  task automatic start_xfer(input bit we, input logic [15:0] addr,
                            input logic [7:0] data, input bit last);
    dma_req = 1'b1;
    dma_we = we;
    dma_addr = addr;
    dma_wdata = data;
    dma_last = last;
    exp_q.push_back(xfer_t'{we, addr, data, last});
  endtask

  task automatic wait_ack();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dma_ack !== 1'b1 && n < 200);
    check("ack_wait", dma_ack, 1'b1);
    dma_req = 1'b0;
  endtask

  task automatic xfer(input bit we, input logic [15:0] addr,
                      input logic [7:0] data, input bit last);
    start_xfer(we, addr, data, last);
    wait_ack();
  endtask

  initial begin
    int a0, g0, r0, n, gap;
    reset_n = 1'b0;
    dma_req = 1'b0;
    dma_we = 1'b0;
    dma_last = 1'b0;
    dma_addr = 16'h0000;
    dma_wdata = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[16'h4000] = 8'hA5;
    repeat (3) @(negedge clk);
    check("rst_busrq", busrq_n, 1'b1);
    check("rst_ack", dma_ack, 1'b0);
    check("rst_rdata", dma_rdata, 8'h00);
    check("rst_owned", bus_owned, 1'b0);
    check("rst_addr", mem_a, 16'h0000);
    check("rst_dout", mem_dout, 8'hFF);
    check("rst_strobes", {mem_mreq_n, mem_rd_n, mem_wr_n}, 3'b111);
    reset_n = 1'b1;
    start_cmp = 1'b1;
    @(negedge clk);

    // single read
    a0 = acks;
    xfer(1'b0, 16'h4000, 8'h00, 1'b1);
    check("t1_rdata", dma_rdata, 8'hA5);
    check("t1_rd_len", last_run, 3);
    check("t1_latency", last_ack_cyc - ak_fall_cyc, 3 + MEM_WAIT);
    @(negedge clk);
    check("t1_busrq_released", busrq_n, 1'b1);
    check("t1_owned", bus_owned, 1'b0);
    check("t1_acks", acks - a0, 1);

    // four-write burst ending on last
    a0 = acks;
    g0 = grants;
    r0 = releases;
    for (int i = 0; i < 4; i++)
      xfer(1'b1, 16'h8000 + 16'(i), 8'h10 + 8'(i), i == 3);
    @(negedge clk);
    check("t2_acks", acks - a0, 4);
    check("t2_grants", grants - g0, 1);
    check("t2_releases", releases - r0, 1);
    check("t2_mem8001", mem[16'h8001], 8'h11);
    check("t2_mem8003", mem[16'h8003], 8'h13);

    // burst cap forces release after four transfers
    g0 = grants;
    r0 = releases;
    for (int i = 0; i < 6; i++)
      xfer(1'b1, 16'h9000 + 16'(i), 8'hC0 + 8'(i), 1'b0);
    @(negedge clk);
    check("t3_grants", grants - g0, 2);
    check("t3_releases", releases - r0, 1);
    check("t3_still_owned", bus_owned, 1'b1);
    xfer(1'b0, 16'h9005, 8'h00, 1'b1);
    check("t3_readback", dma_rdata, 8'hC5);
    @(negedge clk);
    check("t3_final_release", releases - r0, 2);

    // request withdrawn before grant
    a0 = acks;
    no_ack = 1'b1;
    dma_req = 1'b1;
    dma_we = 1'b0;
    dma_last = 1'b1;
    dma_addr = 16'h1234;
    repeat (4) @(negedge clk);
    check("t4_busrq_low", busrq_n, 1'b0);
    check("t4_not_owned", bus_owned, 1'b0);
    dma_req = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_busrq_high", busrq_n, 1'b1);
    check("t4_no_ack", acks - a0, 0);
    no_ack = 1'b0;

    // reset during a write access
    a0 = acks;
    start_xfer(1'b1, 16'hA000, 8'h77, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (mem_wr_n !== 1'b0 && n < 100);
    check("t5_wr_seen", mem_wr_n, 1'b0);
    reset_n = 1'b0;
    dma_req = 1'b0;
    @(negedge clk);
    check("t5_wr_n", mem_wr_n, 1'b1);
    check("t5_mreq_n", mem_mreq_n, 1'b1);
    check("t5_busrq", busrq_n, 1'b1);
    check("t5_owned", bus_owned, 1'b0);
    check("t5_dout", mem_dout, 8'hFF);
    check("t5_ack", dma_ack, 1'b0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_no_ack", acks - a0, 0);

    // back-to-back single transfers: CPU gap between grants
    xfer(1'b0, 16'h4000, 8'h00, 1'b1);
    start_xfer(1'b0, 16'h8002, 8'h00, 1'b1);
    n = 0;
    gap = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busak_n !== 1'b1 && n < 50);
    while (busrq_n === 1'b1 && n < 100) begin
      gap++;
      @(negedge clk);
      n++;
    end
`ifdef DMA_HOLDOFF_EN
    check("t6_holdoff_gap", gap >= HOLDOFF, 1'b1);
`else
    check("t6_release_gap", gap, 2);
`endif
    wait_ack();
    check("t6_rdata", dma_rdata, 8'h12);
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
